edge_detect_multi: RTL
======================

# edge_detect_multi

Parametrised multi-channel edge detector for asynchronous control inputs such as camera VSYNC/HREF, buttons and external strobes. Each channel has an input synchronizer, a glitch filter, rising/falling edge pulse generation, a per-channel edge-mode select, a sticky event flag and a saturating event counter. It sits between raw pins and the capture/packetiser control logic. It generalises the single-channel, unfiltered falling-edge detector.

## Interface
- CH, 4 — number of independent channels (≥1)
- SYNC_STAGES, 2 — synchronizer flops per channel (≥2)
- FILT_LEN, 3 — consecutive cycles the synced input must differ from the filtered level before the level changes (≥1)
- CNT_W, 16 — width of each per-channel event counter (≥1)

- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- sig_in  in  CH  raw asynchronous inputs; bit i is channel i
- mode  in  2*CH  per-channel event select, bits [2i+1:2i]: 00 off, 01 rise, 10 fall, 11 both
- sticky_clr  in  CH  synchronous clear of event_sticky[i]
- cnt_clr  in  CH  synchronous clear of channel i's counter
- level_out  out  CH  filtered, synchronized level
- rise_pulse  out  CH  one-cycle pulse on a filtered rising edge
- fall_pulse  out  CH  one-cycle pulse on a filtered falling edge
- event_pulse  out  CH  one-cycle pulse on an edge selected by mode
- event_sticky  out  CH  latched event flag
- edge_cnt  out  CH*CNT_W  per-channel event count; channel i is bits [CNT_W*i +: CNT_W]

## Operation
- Reset: the sync chain, filter counters, level_out, all pulses, event_sticky and edge_cnt are 0. The filtered level starts at 0, so an input held high through reset produces one rise_pulse after the latency L.
- Synchronizer: sig_in[i] passes through SYNC_STAGES flops. The last stage is s[i].
- Filter:
  - A per-channel counter fc (width $clog2(FILT_LEN+1)) counts consecutive cycles where s[i] ≠ level_out[i].
  - When s[i] ≠ level_out[i] and fc = FILT_LEN-1, level_out[i] toggles and fc clears.
  - When s[i] = level_out[i], fc clears, even mid-count.
  - A synced excursion shorter than FILT_LEN cycles is rejected and produces no pulse.
- Edge detect:
  - rise_pulse[i] is registered high for exactly one cycle after level_out[i] goes 0→1.
  - fall_pulse[i] is registered high for exactly one cycle after level_out[i] goes 1→0.
  - rise_pulse and fall_pulse are independent of mode.
- Event: event_pulse[i] = (rise_pulse[i] & mode[2i]) | (fall_pulse[i] & mode[2i+1]). It is combinational from registered pulses and the mode input.
- Sticky: event_sticky[i] is set by event_pulse[i] and cleared by sticky_clr[i]. If both occur in the same cycle, set wins.
- Counter:
  - edge_cnt[i] increments on event_pulse[i] and saturates at 2^CNT_W-1 (no wrap).
  - cnt_clr[i] with no event gives 0. cnt_clr[i] together with event_pulse[i] gives 1.
- Mode change: takes effect on the same cycle's event_pulse. Pulses already generated are not replayed.
- Channels share no state. Simultaneous activity on all channels is handled independently with no arbitration.

## Timing
- Latency L = SYNC_STAGES + FILT_LEN. Hold sig_in[i] stable at the new value before sampling edge N.
  - level_out[i] changes at edge N+L-1.
  - rise_pulse or fall_pulse is high in the cycle after edge N+L.
  - Defaults: L = 5.
- Minimum detectable pulse width at sig_in: FILT_LEN+1 clk cycles, including synchronizer uncertainty. Width ≤ FILT_LEN-1 cycles is always rejected.
- Maximum event rate per channel: one edge every FILT_LEN cycles. rise_pulse and fall_pulse are never high in the same cycle.
- event_sticky and edge_cnt update at the clock edge following event_pulse.
- Asynchronous reset mid-count or mid-pulse forces all outputs to 0 immediately. After release, behaviour is as from power-up.

## Test plan
- Reset release with sig_in=4'b0001 (defaults) -> level_out[0]=1 and one rise_pulse[0] after 5 cycles; no other channel toggles; edge_cnt stays 0 because mode=0.
- mode[1:0]=11, 10-cycle high pulse on ch0 -> one rise_pulse and one fall_pulse 5 cycles after each transition; edge_cnt[0]=2; event_sticky[0]=1.
- Glitch: 1- and 2-cycle highs on ch1 with FILT_LEN=3 -> no pulses, level_out[1]=0. A 4-cycle high -> exactly one rise_pulse.
- mode=01 (rise only) over 3 full pulses -> edge_cnt=3 and fall_pulse seen 3 times but not counted. Then mode=00 -> count frozen.
- CNT_W=2, 5 events -> edge_cnt=3 (saturated). Then cnt_clr with a coincident event -> 1. sticky_clr with a coincident event -> sticky stays 1.
- rst_n asserted while fc=2 and again during a pulse cycle -> all outputs 0 at once; no spurious pulse after release when sig_in=0.

Source files
------------

// File: rtl/edge_detect_multi.sv
// Multi-channel edge detector: per-channel synchronizer, glitch filter, rise/fall
// pulses, mode-selected events, sticky flag and saturating event counter.
module edge_detect_multi #(
  parameter int CH          = 4,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 3,
  parameter int CNT_W       = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CH-1:0]       sig_in,
  input  logic [2*CH-1:0]     mode,
  input  logic [CH-1:0]       sticky_clr,
  input  logic [CH-1:0]       cnt_clr,
  output logic [CH-1:0]       level_out,
  output logic [CH-1:0]       rise_pulse,
  output logic [CH-1:0]       fall_pulse,
  output logic [CH-1:0]       event_pulse,
  output logic [CH-1:0]       event_sticky,
  output logic [CH*CNT_W-1:0] edge_cnt
);

  localparam int FC_W = $clog2(FILT_LEN + 1);
  localparam logic [FC_W-1:0]  FC_LAST = FC_W'(FILT_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  for (genvar i = 0; i < CH; i++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_q;
    logic [FC_W-1:0]        fc_q;
    logic                   level_q;
    logic                   level_d;
    logic                   rise_q;
    logic                   fall_q;
    logic                   sticky_q;
    logic [CNT_W-1:0]       cnt_q;
    logic                   s;
    logic                   ev;

    assign s  = sync_q[SYNC_STAGES-1];
    assign ev = (rise_q & mode[2*i]) | (fall_q & mode[2*i+1]);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sync_q <= '0;
      end else begin
        sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in[i]};
      end
    end

    // The filtered level only flips after FILT_LEN consecutive disagreeing
    // cycles; any agreeing cycle restarts the count.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        fc_q    <= '0;
        level_q <= 1'b0;
        level_d <= 1'b0;
        rise_q  <= 1'b0;
        fall_q  <= 1'b0;
      end else begin
        level_d <= level_q;
        rise_q  <= level_q & ~level_d;
        fall_q  <= ~level_q & level_d;
        if (s == level_q) begin
          fc_q <= '0;
        end else if (fc_q == FC_LAST) begin
          fc_q    <= '0;
          level_q <= ~level_q;
        end else begin
          fc_q <= fc_q + FC_W'(1);
        end
      end
    end

    // A coincident event beats a clear for both the flag and the counter.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sticky_q <= 1'b0;
        cnt_q    <= '0;
      end else begin
        if (ev) begin
          sticky_q <= 1'b1;
        end else if (sticky_clr[i]) begin
          sticky_q <= 1'b0;
        end
        if (cnt_clr[i]) begin
          cnt_q <= CNT_W'(ev);
        end else if (ev && (cnt_q != CNT_MAX)) begin
          cnt_q <= cnt_q + CNT_W'(1);
        end
      end
    end

    assign level_out[i]                 = level_q;
    assign rise_pulse[i]                = rise_q;
    assign fall_pulse[i]                = fall_q;
    assign event_pulse[i]               = ev;
    assign event_sticky[i]              = sticky_q;
    assign edge_cnt[CNT_W*i +: CNT_W]   = cnt_q;
  end

endmodule
